// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table sequencer
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // y = ~b&~c | a&~b
  localparam logic [7:0] SILLY_TT = 8'h31;

  function automatic int nvec(input int n_in);
    return 2 ** n_in;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - per-vector hold counter; tick marks the last cycle of a hold window
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Wraps by itself on tick so the next vector starts a fresh window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors and checks y_i against a golden table
// Optional mismatch_mask output when TT_ERRLOG_EN is defined.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int                    N_IN        = 3,
  parameter int                    HOLD_CYCLES = 10,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED    = SILLY_TT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_o,
  input  logic                   y_i,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
`ifdef TT_ERRLOG_EN
  output logic [(1<<N_IN)-1:0]   mismatch_mask,
`endif
  output logic [N_IN-1:0]        fail_vec
);

  localparam int NVEC = nvec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

  tt_state_e       state, state_d;
  logic [N_IN-1:0] vec_d, fail_d;
  logic [N_IN:0]   err_d;
  logic            busy_d, done_d, pass_d;
  logic            clr, en, tick, mism;
`ifdef TT_ERRLOG_EN
  logic [NVEC-1:0] mask_d;
`endif

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vec_o     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
`ifdef TT_ERRLOG_EN
      mismatch_mask <= '0;
`endif
    end else begin
      state     <= state_d;
      vec_o     <= vec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_vec  <= fail_d;
`ifdef TT_ERRLOG_EN
      mismatch_mask <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    vec_d   = vec_o;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    err_d   = err_count;
    fail_d  = fail_vec;
`ifdef TT_ERRLOG_EN
    mask_d  = mismatch_mask;
`endif
    clr     = 1'b0;
    en      = 1'b0;
    mism    = (y_i != EXPECTED[vec_o]);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
`ifdef TT_ERRLOG_EN
          mask_d  = '0;
`endif
          clr     = 1'b1;
        end
      end
      RUN: begin
        en = 1'b1;
        if (tick) begin
          if (mism) begin
            err_d = err_count + 1'b1;
            if (err_count == '0) fail_d = vec_o;
`ifdef TT_ERRLOG_EN
            mask_d[vec_o] = 1'b1;
`endif
          end
          // Pass is decided from the count including this final sample
          if (vec_o == LAST_VEC) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_o + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] vec_o;
  logic       y_i;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
`ifdef TT_ERRLOG_EN
  logic [7:0] mismatch_mask;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0; // 0 good function, 1 vector 3 inverted, 2 y tied low

  truth_table_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec_o     (vec_o),
    .y_i       (y_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
`ifdef TT_ERRLOG_EN
    .mismatch_mask (mismatch_mask),
`endif
    .fail_vec  (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic good;
    good = (~vec_o[1] & ~vec_o[0]) | (vec_o[2] & ~vec_o[1]);
    y_i  = good;
    if (mode == 1 && vec_o == 3'd3) y_i = ~good;
    if (mode == 2) y_i = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start pulse, then 80 RUN cycles; optional extra start pulse at RUN cycle pulse_at
  task automatic sweep(input int pulse_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("vec_after_start", vec_o, 0);
    check("err_after_start", err_count, 0);
    for (int i = 1; i < 80; i++) begin
      if (i == pulse_at) begin
        check("vec_at_mid_start", vec_o, 2);
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("done_before_end", done, 0);
    check("vec_last", vec_o, 7);
    @(negedge clk);
    check("done_at_end", done, 1);
    check("busy_at_end", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail", fail_vec, 0);
    check("rst_vec", vec_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // Clean sweep
    mode = 0;
    sweep(-1);
    check("good_pass", pass, 1);
    check("good_err", err_count, 0);
    check("good_fail", fail_vec, 0);
`ifdef TT_ERRLOG_EN
    check("good_mask", mismatch_mask, 8'h00);
`endif

    // Vector 3 inverted, started from DONE
    mode = 1;
    sweep(-1);
    check("inv3_pass", pass, 0);
    check("inv3_err", err_count, 1);
    check("inv3_fail", fail_vec, 3);
`ifdef TT_ERRLOG_EN
    check("inv3_mask", mismatch_mask, 8'h08);
`endif

    // y tied low
    mode = 2;
    sweep(-1);
    check("zero_pass", pass, 0);
    check("zero_err", err_count, 3);
    check("zero_fail", fail_vec, 0);
`ifdef TT_ERRLOG_EN
    check("zero_mask", mismatch_mask, 8'h31);
`endif

    // Reset mid-sweep at vector 5 (errors already logged at 0 and 4)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (51) @(negedge clk);
    check("pre_rst_vec", vec_o, 5);
    check("pre_rst_err", err_count, 2);
    reset = 1'b1;
    #1;
    check("mid_rst_vec", vec_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_fail", fail_vec, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mode = 0;
    sweep(-1);
    check("post_rst_pass", pass, 1);
    check("post_rst_err", err_count, 0);

    // start during RUN at vector 2 is ignored
    sweep(25);
    check("mid_start_pass", pass, 1);

    // start held high into DONE: one done cycle, then restart
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (79) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("held_done_seen", done, 1);
    check("held_busy_low", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("held_restart_busy", busy, 1);
    check("held_restart_done", done, 0);
    check("held_restart_vec", vec_o, 0);
    repeat (85) @(negedge clk);
    check("held_final_done", done, 1);
    check("held_final_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
